// File: rtl/strip_trigger_rx.sv
// strip_trigger_rx: reassembles 3-lane serial strip trigger frames into a show-ahead FIFO with error counters.
// Define STRIP_RX_TRAILER_CHECK_EN to drop frames whose trailer bit is 1 and count them in err_trl_cnt.
`timescale 1ns/1ps
module strip_trigger_rx #(
    parameter int FIFO_AW   = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk320,
    input  logic                 reset,
    input  logic                 trig_en,
    input  logic                 trig_d0,
    input  logic                 trig_d1,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [4:0]           out_phi_id,
    output logic [7:0]           out_bandid,
    output logic [11:0]          out_bcid,
    output logic [15:0]          frame_cnt,
`ifdef STRIP_RX_TRAILER_CHECK_EN
    output logic [ERR_CNT_W-1:0] err_trl_cnt,
`endif
    output logic [ERR_CNT_W-1:0] err_len_cnt,
    output logic [ERR_CNT_W-1:0] err_ovf_cnt
);
    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;

    logic             en_r, d0_r, d1_r, lanes_valid;
    logic [1:0]       state;
    logic [3:0]       bit_cnt;
    logic [12:0]      sr0, sr1;
    logic [24:0]      mem [2**FIFO_AW];
    logic [FIFO_AW:0] wptr, rptr;
    logic             shift, frame_end, len_err, trl_bad, push_req, pop, full, push_ok, ovf;

    assign shift     = en_r && (state == IDLE || (state == SHIFT && bit_cnt != 4'd13));
    assign frame_end = state == SHIFT && !en_r && bit_cnt == 4'd13;
    // long (en still high at 13 bits) and short (en low before 13 bits) both collapse to this
    assign len_err   = state == SHIFT && (en_r == (bit_cnt == 4'd13));
`ifdef STRIP_RX_TRAILER_CHECK_EN
    assign trl_bad   = sr0[0];
`else
    logic unused_trl;
    assign unused_trl = sr0[0];
    assign trl_bad   = 1'b0;
`endif
    assign push_req  = frame_end && !trl_bad;
    assign out_valid = wptr != rptr;
    assign pop       = out_valid && out_ready;
    assign full      = wptr[FIFO_AW] != rptr[FIFO_AW] && wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0];
    assign push_ok   = push_req && (!full || pop);
    assign ovf       = push_req && full && !pop;
    assign {out_phi_id, out_bandid, out_bcid} = mem[rptr[FIFO_AW-1:0]];

    // en_r holds its reset value for one edge, so WAIT_IDLE ignores it until it has sampled the lane
    always_ff @(posedge clk320 or posedge reset) begin
        if (reset) begin
            en_r        <= 1'b0;
            d0_r        <= 1'b0;
            d1_r        <= 1'b0;
            lanes_valid <= 1'b0;
            state       <= WAIT_IDLE;
            bit_cnt     <= '0;
            sr0         <= '0;
            sr1         <= '0;
        end else begin
            en_r        <= trig_en;
            d0_r        <= trig_d0;
            d1_r        <= trig_d1;
            lanes_valid <= 1'b1;
            if (shift) begin
                sr0     <= {sr0[11:0], d0_r};
                sr1     <= {sr1[11:0], d1_r};
                bit_cnt <= state == IDLE ? 4'd1 : bit_cnt + 4'd1;
            end
            if (state == WAIT_IDLE) begin
                if (!en_r && lanes_valid) state <= IDLE;
            end else if (state == IDLE) begin
                if (en_r) state <= SHIFT;
            end else if (!shift) begin
                state <= en_r ? WAIT_IDLE : IDLE;
            end
        end
    end

    always_ff @(posedge clk320 or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            frame_cnt   <= '0;
            err_len_cnt <= '0;
            err_ovf_cnt <= '0;
`ifdef STRIP_RX_TRAILER_CHECK_EN
            err_trl_cnt <= '0;
`endif
            for (int i = 0; i < 2**FIFO_AW; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr[FIFO_AW-1:0]] <= {sr1, sr0[12:1]};
                wptr      <= wptr + (FIFO_AW+1)'(1);
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (pop) rptr <= rptr + (FIFO_AW+1)'(1);
            if (len_err && !(&err_len_cnt)) err_len_cnt <= err_len_cnt + ERR_CNT_W'(1);
            if (ovf && !(&err_ovf_cnt)) err_ovf_cnt <= err_ovf_cnt + ERR_CNT_W'(1);
`ifdef STRIP_RX_TRAILER_CHECK_EN
            if (frame_end && trl_bad && !(&err_trl_cnt)) err_trl_cnt <= err_trl_cnt + ERR_CNT_W'(1);
`endif
        end
    end
endmodule
